// File: rtl/leaf_uart_boot_if.sv
// Core-side bundle of the Leaf UART boot loader.
// Covers instruction-memory writes, core reset and the console byte port.
interface leaf_uart_boot_if #(
   parameter int AW = 6
);
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_rst_n;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          tx_busy;
   logic          rx_valid;
   logic [7:0]    rx_data;

   modport master (
      output mem_we,
      output mem_addr,
      output mem_wdata,
      output cpu_rst_n,
      output tx_busy,
      output rx_valid,
      output rx_data,
      input  tx_start,
      input  tx_data
   );

   modport slave (
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      input  cpu_rst_n,
      input  tx_busy,
      input  rx_valid,
      input  rx_data,
      output tx_start,
      output tx_data
   );
endinterface

// File: rtl/leaf_uart_boot.sv
// UART boot loader and console for the Leaf core.
// Loads 0x77/size/payload into instruction memory, then releases the core.
module leaf_uart_boot #(
   parameter int          CLKS_PER_BIT = 434,
   parameter logic [7:0]  LOAD_CMD     = 8'h77,
   parameter int          AW           = 6
) (
   input  logic clock,
   input  logic resetb,
   input  logic rx,
   output logic tx,
   leaf_uart_boot_if.master bus
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      S_WAIT_CMD,
      S_SIZE,
      S_DATA,
      S_FIN,
      S_RUN
   } state_t;

   rx_state_t r_rx_state;
   rx_state_t w_rx_next;
   logic      r_rx_s1;
   logic      r_rx_s2;
   logic      r_rx_s3;
   logic [CW-1:0] r_rx_cnt;
   logic [2:0]    r_rx_bit;
   logic [7:0]    r_rx_shift;
   logic          r_byte_stb;
   logic          w_rx_fall;
   logic          w_rx_half;
   logic          w_rx_full;

   logic          r_tx;
   logic          r_tx_busy;
   logic [8:0]    r_tx_shift;
   logic [CW-1:0] r_tx_cnt;
   logic [3:0]    r_tx_bit;

   state_t        r_state;
   state_t        w_next;
   logic [7:0]    r_size;
   logic [7:0]    r_cnt;
   logic [1:0]    r_lane;
   logic [31:0]   r_word;
   logic [31:0]   w_word;
   logic          w_last;
   logic          w_write;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_addr;
   logic [31:0]   r_mem_wdata;
   logic          r_rx_valid;
   logic [7:0]    r_rx_data;

   // rx is asynchronous; the third stage only serves edge detection
   assign w_rx_fall = r_rx_s3 & ~r_rx_s2;
   assign w_rx_half = (r_rx_cnt == HALF_END);
   assign w_rx_full = (r_rx_cnt == BIT_END);

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
         r_rx_s3 <= 1'b1;
      end else begin
         r_rx_s1 <= rx;
         r_rx_s2 <= r_rx_s1;
         r_rx_s3 <= r_rx_s2;
      end
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_rx_state <= RX_IDLE;
      end else begin
         r_rx_state <= w_rx_next;
      end
   end

   always_comb begin
      w_rx_next = r_rx_state;
      unique case (r_rx_state)
         RX_IDLE: begin
            if (w_rx_fall) w_rx_next = RX_START;
         end
         RX_START: begin
            if (w_rx_half)
               w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
         end
         RX_DATA: begin
            if (w_rx_full && r_rx_bit == 3'd7)
               w_rx_next = RX_STOP;
         end
         RX_STOP: begin
            if (w_rx_full) w_rx_next = RX_IDLE;
         end
         default: w_rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
         r_byte_stb <= 1'b0;
      end else begin
         r_byte_stb <= (r_rx_state == RX_STOP) && w_rx_full && r_rx_s2;
         if (r_rx_state == RX_IDLE) begin
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
         end else if ((r_rx_state == RX_START && w_rx_half) || w_rx_full) begin
            r_rx_cnt <= '0;
         end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
         end
         if (r_rx_state == RX_DATA && w_rx_full) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
         end
      end
   end

   // start bit goes out the cycle after tx_start; shift holds data then stop
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_tx       <= 1'b1;
         r_tx_busy  <= 1'b0;
         r_tx_shift <= '0;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
      end else if (!r_tx_busy) begin
         if (bus.tx_start) begin
            r_tx_busy  <= 1'b1;
            r_tx       <= 1'b0;
            r_tx_shift <= {1'b1, bus.tx_data};
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
         end
      end else if (r_tx_cnt == BIT_END) begin
         r_tx_cnt <= '0;
         if (r_tx_bit == 4'd9) begin
            r_tx_busy <= 1'b0;
            r_tx      <= 1'b1;
         end else begin
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= {1'b1, r_tx_shift[8:1]};
            r_tx_bit   <= r_tx_bit + 1'b1;
         end
      end else begin
         r_tx_cnt <= r_tx_cnt + 1'b1;
      end
   end

   assign w_last  = (r_cnt + 8'd1 == r_size);
   assign w_write = (r_state == S_DATA) && r_byte_stb &&
                    (r_lane == 2'd3 || w_last);

   always_comb begin
      w_word = r_word;
      w_word[8*r_lane +: 8] = r_rx_shift;
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_state <= S_WAIT_CMD;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_WAIT_CMD: begin
            if (r_byte_stb && r_rx_shift == LOAD_CMD)
               w_next = S_SIZE;
         end
         S_SIZE: begin
            if (r_byte_stb)
               w_next = (r_rx_shift == 8'd0) ? S_RUN : S_DATA;
         end
         S_DATA: begin
            if (r_byte_stb && w_last) w_next = S_FIN;
         end
         S_FIN:   w_next = S_RUN;
         S_RUN:   w_next = S_RUN;
         default: w_next = S_WAIT_CMD;
      endcase
   end

   // r_word is cleared after every write so a short tail is zero-padded
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_size      <= '0;
         r_cnt       <= '0;
         r_lane      <= '0;
         r_word      <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rx_valid  <= 1'b0;
         r_rx_data   <= '0;
      end else begin
         r_mem_we   <= w_write;
         r_rx_valid <= (r_state == S_RUN) && r_byte_stb;
         if (r_mem_we) r_mem_addr <= r_mem_addr + 1'b1;
         if (r_state == S_SIZE && r_byte_stb) begin
            r_size <= r_rx_shift;
            r_cnt  <= '0;
            r_lane <= '0;
            r_word <= '0;
         end
         if (r_state == S_DATA && r_byte_stb) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_write) begin
               r_mem_wdata <= w_word;
               r_word      <= '0;
               r_lane      <= '0;
            end else begin
               r_word <= w_word;
               r_lane <= r_lane + 1'b1;
            end
         end
         if (r_state == S_RUN && r_byte_stb) r_rx_data <= r_rx_shift;
      end
   end

   assign tx            = r_tx;
   assign bus.tx_busy   = r_tx_busy;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.cpu_rst_n = (r_state == S_RUN);
   assign bus.rx_valid  = r_rx_valid;
   assign bus.rx_data   = r_rx_data;

endmodule

// File: tb/tb_leaf_uart_boot.sv
// Directed bench for leaf_uart_boot: boot load, framing errors,
// mid-load reset, console receive and transmit framing.
module tb_leaf_uart_boot;
   localparam int CPB = 16;

   typedef logic [7:0] byte_q_t[$];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx = 1'b1;
   logic tx;
   logic tx2;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;
   int n_rxv = 0;
   int tx_low = 0;
   logic [5:0]  wr_a[$];
   logic [31:0] wr_d[$];
   byte_q_t seq;

   always #5 clk = ~clk;

   leaf_uart_boot_if #(.AW(6)) bus ();
   leaf_uart_boot_if #(.AW(6)) bus2 ();

   leaf_uart_boot #(.CLKS_PER_BIT(CPB)) dut (
      .clock  (clk),
      .resetb (rst_n),
      .rx     (rx),
      .tx     (tx),
      .bus    (bus.master)
   );

   leaf_uart_boot u_tx (
      .clock  (clk),
      .resetb (rst_n),
      .rx     (1'b1),
      .tx     (tx2),
      .bus    (bus2.master)
   );

   always @(negedge clk) begin
      if (bus.mem_we) begin
         wr_a.push_back(bus.mem_addr);
         wr_d.push_back(bus.mem_wdata);
      end
      if (bus.rx_valid) n_rxv++;
      if (tx !== 1'b1) tx_low++;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk) rx = 1'b0;
      cycles(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         cycles(CPB);
      end
      rx = stop_bit;
      cycles(CPB);
      rx = 1'b1;
      cycles(2 * CPB);
   endtask

   task automatic send_q(input byte_q_t s);
      foreach (s[i]) send_byte(s[i], 1'b1);
      cycles(4 * CPB);
   endtask

   task automatic clear_log();
      wr_a.delete();
      wr_d.delete();
      n_rxv = 0;
   endtask

   task automatic do_reset();
      @(negedge clk) rst_n = 1'b0;
      cycles(3);
      rst_n = 1'b1;
      cycles(2);
      clear_log();
   endtask

   task automatic check_wr(input string tag, input int idx,
                           input logic [5:0] a, input logic [31:0] d);
      if (idx < wr_a.size()) begin
         check({tag, " addr"}, 32'(wr_a[idx]), 32'(a));
         check({tag, " data"}, wr_d[idx], d);
      end else begin
         check({tag, " present"}, wr_a.size(), idx + 1);
      end
   endtask

   task automatic check_prog(input string tag);
      check({tag, " nwr"}, wr_a.size(), 3);
      check_wr({tag, " w0"}, 0, 6'd0, 32'h0410_0293);
      check_wr({tag, " w1"}, 1, 6'd1, 32'h0050_0623);
      check_wr({tag, " w2"}, 2, 6'd2, 32'h0000_006F);
      check({tag, " cpu_rst_n"}, bus.cpu_rst_n, 1);
      check({tag, " addr"}, bus.mem_addr, 3);
   endtask

   initial begin
      int bad;
      int k;
      int busy_n;
      logic [9:0] frame;
      logic [9:0] exp_frame;

      bus.tx_start = 1'b0;
      bus.tx_data  = 8'h00;
      bus2.tx_start = 1'b0;
      bus2.tx_data  = 8'h00;
      cycles(3);
      check("rst tx", tx, 1);
      check("rst mem_we", bus.mem_we, 0);
      check("rst mem_addr", bus.mem_addr, 0);
      check("rst mem_wdata", bus.mem_wdata, 0);
      check("rst cpu_rst_n", bus.cpu_rst_n, 0);
      check("rst tx_busy", bus.tx_busy, 0);
      check("rst rx_valid", bus.rx_valid, 0);
      check("rst rx_data", bus.rx_data, 0);
      rst_n = 1'b1;

      bad = 0;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || bus.cpu_rst_n !== 1'b0) bad++;
      end
      check("idle hold", bad, 0);

      seq = '{8'h77, 8'h0C, 8'h93, 8'h02, 8'h10, 8'h04, 8'h23,
              8'h06, 8'h50, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
      send_q(seq);
      check_prog("load");

      send_byte(8'h77, 1'b1);
      cycles(CPB);
      check("run rxv", n_rxv, 1);
      check("run rx_data", bus.rx_data, 8'h77);
      check("run nwr", wr_a.size(), 3);
      check("run cpu", bus.cpu_rst_n, 1);

      do_reset();
      check("rerst cpu", bus.cpu_rst_n, 0);
      check("rerst addr", bus.mem_addr, 0);
      send_byte(8'h55, 1'b1);
      cycles(CPB);
      check("junk nwr", wr_a.size(), 0);
      check("junk cpu", bus.cpu_rst_n, 0);
      send_q(seq);
      check_prog("junk load");

      do_reset();
      send_byte(8'h77, 1'b1);
      send_byte(8'h05, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'hEE, 1'b0);
      send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b1);
      check("ferr cpu mid", bus.cpu_rst_n, 0);
      send_byte(8'h55, 1'b1);
      cycles(4 * CPB);
      check("ferr nwr", wr_a.size(), 2);
      check_wr("ferr w0", 0, 6'd0, 32'h4433_2211);
      check_wr("ferr w1", 1, 6'd1, 32'h0000_0055);
      check("ferr cpu", bus.cpu_rst_n, 1);
      check("ferr rxv", n_rxv, 0);

      do_reset();
      seq = '{8'h77, 8'h00};
      send_q(seq);
      check("n0 cpu", bus.cpu_rst_n, 1);
      check("n0 nwr", wr_a.size(), 0);

      do_reset();
      seq = '{8'h77, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      send_q(seq);
      check("abort nwr pre", wr_a.size(), 1);
      check_wr("abort w0", 0, 6'd0, 32'h0403_0201);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort cpu", bus.cpu_rst_n, 0);
      check("abort addr", bus.mem_addr, 0);
      cycles(2);
      rst_n = 1'b1;
      cycles(20 * CPB);
      check("abort nwr post", wr_a.size(), 1);
      check("abort cpu post", bus.cpu_rst_n, 0);
      seq = '{8'h77, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
      send_q(seq);
      check("reload nwr", wr_a.size(), 2);
      check_wr("reload w", 1, 6'd0, 32'hD4C3_B2A1);
      check("reload cpu", bus.cpu_rst_n, 1);
      check("no echo", tx_low, 0);

      exp_frame = 10'b10_1000_0010;
      frame = '0;
      k = 0;
      busy_n = 0;
      @(negedge clk);
      bus2.tx_data  = 8'h41;
      bus2.tx_start = 1'b1;
      for (int m = 1; m <= 4400; m++) begin
         @(negedge clk);
         bus2.tx_start = 1'b0;
         if (m == 1000) begin
            bus2.tx_data  = 8'hFF;
            bus2.tx_start = 1'b1;
         end
         if (bus2.tx_busy) busy_n++;
         if (m >= 218 && (m - 218) % 434 == 0 && k < 10) begin
            frame[k] = tx2;
            k++;
         end
      end
      for (int b = 0; b < 10; b++)
         check($sformatf("tx bit%0d", b), frame[b], exp_frame[b]);
      check("tx busy len", busy_n, 4340);
      check("tx idle", tx2, 1);
      check("tx busy end", bus2.tx_busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
